// File: rtl/msp_inst_encoder.sv
// Field-to-opcode MSP430 instruction encoder that streams the 1-3 words of each
// accepted instruction into program memory, one registered write per cycle.
module msp_inst_encoder #(
    parameter int                 PMEM_AW   = 11,
    parameter logic [PMEM_AW-1:0] BASE_ADDR = '0
) (
    input  logic               mclk,
    input  logic               puc_rst,
    // Handshake: a request transfers on a rising mclk edge where req_valid and
    // req_ready are both high; req_ready never depends on req_valid.
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_fmt,
    input  logic [3:0]         req_op,
    input  logic               req_bw,
    input  logic [1:0]         req_as,
    input  logic               req_ad,
    input  logic [3:0]         req_src,
    input  logic [3:0]         req_dst,
    input  logic [9:0]         req_jofs,
    input  logic [15:0]        req_ext1,
    input  logic [15:0]        req_ext2,
    input  logic [15:0]        req_raw,
    input  logic               addr_load,
    input  logic [PMEM_AW-1:0] addr_val,
    output logic               pmem_wen,
    output logic [PMEM_AW-1:0] pmem_addr,
    output logic [15:0]        pmem_din,
    output logic [15:0]        inst_count,
    output logic               enc_err,
    output logic               addr_wrap,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPC  = 2'd1,
        EXT1 = 2'd2,
        EXT2 = 2'd3
    } state_t;

    localparam logic [1:0] FMT_SINGLE = 2'd0;
    localparam logic [1:0] FMT_JUMP   = 2'd1;
    localparam logic [1:0] FMT_TWO    = 2'd2;

    localparam logic [PMEM_AW-1:0] PTR_ONE = {{(PMEM_AW-1){1'b0}}, 1'b1};

    state_t             state_q;
    logic [PMEM_AW-1:0] ptr_q;
    logic [1:0]         n_q;
    logic [15:0]        ext1_q;
    logic [15:0]        ext2_q;
    logic               pmem_wen_q;
    logic [PMEM_AW-1:0] pmem_addr_q;
    logic [15:0]        pmem_din_q;
    logic [15:0]        inst_count_q;
    logic               enc_err_q;
    logic               addr_wrap_q;

    // Opcode construction and word count for the fields currently on the request bus
    logic [15:0] enc_opc;
    logic        enc_legal;
    logic        is_reti;
    logic        src_ext;
    logic        dst_ext;
    logic [1:0]  enc_n;

    always_comb begin
        enc_opc   = req_raw;
        enc_legal = 1'b1;
        src_ext   = 1'b0;
        is_reti   = (req_fmt == FMT_SINGLE) && (req_op == 4'd6);
        case (req_fmt)
            FMT_SINGLE: begin
                enc_legal = (req_op <= 4'd6);
                enc_opc   = is_reti ? 16'h1300
                                    : {6'b000100, req_op[2:0], req_bw, req_as, req_src};
            end
            FMT_JUMP: begin
                enc_legal = !req_op[3];
                enc_opc   = {3'b001, req_op[2:0], req_jofs};
            end
            FMT_TWO: begin
                enc_legal = (req_op >= 4'd4);
                enc_opc   = {req_op, req_src, req_ad, req_bw, req_as, req_dst};
            end
            default: begin
                enc_legal = 1'b1;
                enc_opc   = req_raw;
            end
        endcase
        // Indexed/absolute/symbolic (as=01) and immediate @PC+ (as=11, r0) carry a word;
        // r3 and r2 with as=1x are constant-generator encodings and carry none.
        if (((req_fmt == FMT_SINGLE) && !is_reti) || (req_fmt == FMT_TWO)) begin
            src_ext = ((req_as == 2'b01) && (req_src != 4'd3)) ||
                      ((req_as == 2'b11) && (req_src == 4'd0));
        end
        dst_ext = (req_fmt == FMT_TWO) && req_ad;
        enc_n   = 2'd1 + {1'b0, src_ext} + {1'b0, dst_ext};
    end

    logic accept;
    logic reject;

    assign req_ready = (state_q == IDLE) && !addr_load;
    assign accept    = req_valid && req_ready && enc_legal;
    assign reject    = req_valid && req_ready && !enc_legal;

    // Which word (if any) is launched at the coming edge, and whether the word
    // on the bus right now is the final one of its instruction.
    logic        wr_go;
    logic [15:0] wr_data;
    logic        last_word;

    always_comb begin
        wr_go     = 1'b0;
        wr_data   = enc_opc;
        last_word = 1'b0;
        case (state_q)
            IDLE: begin
                wr_go   = accept;
                wr_data = enc_opc;
            end
            OPC: begin
                last_word = (n_q == 2'd1);
                wr_go     = !last_word;
                wr_data   = ext1_q;
            end
            EXT1: begin
                last_word = (n_q == 2'd2);
                wr_go     = !last_word;
                wr_data   = ext2_q;
            end
            default: begin
                last_word = 1'b1;
            end
        endcase
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q      <= IDLE;
            ptr_q        <= BASE_ADDR;
            n_q          <= 2'd0;
            ext1_q       <= 16'h0000;
            ext2_q       <= 16'h0000;
            pmem_wen_q   <= 1'b0;
            pmem_addr_q  <= '0;
            pmem_din_q   <= 16'h0000;
            inst_count_q <= 16'h0000;
            enc_err_q    <= 1'b0;
            addr_wrap_q  <= 1'b0;
        end else begin
            pmem_wen_q <= wr_go;
            enc_err_q  <= reject;
            if (wr_go) begin
                pmem_addr_q <= ptr_q;
                pmem_din_q  <= wr_data;
                ptr_q       <= ptr_q + PTR_ONE;
                if (&ptr_q) begin
                    addr_wrap_q <= 1'b1;
                end
            end
            if (last_word) begin
                inst_count_q <= inst_count_q + 16'd1;
            end
            case (state_q)
                IDLE: begin
                    if (addr_load) begin
                        ptr_q <= addr_val;
                    end else if (accept) begin
                        state_q <= OPC;
                        n_q     <= enc_n;
                        ext1_q  <= req_ext1;
                        ext2_q  <= req_ext2;
                    end
                end
                OPC:     state_q <= last_word ? IDLE : EXT1;
                EXT1:    state_q <= last_word ? IDLE : EXT2;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pmem_wen   = pmem_wen_q;
    assign pmem_addr  = pmem_addr_q;
    assign pmem_din   = pmem_din_q;
    assign inst_count = inst_count_q;
    assign enc_err    = enc_err_q;
    assign addr_wrap  = addr_wrap_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_msp_inst_encoder.sv
// Randomized and directed bench for msp_inst_encoder: a field-level reference
// model predicts every (address, word) write, a monitor pops and compares them.
module tb_msp_inst_encoder;

    localparam int AW    = 11;
    localparam int W     = AW + 16;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        logic [1:0]  fmt;
        logic [3:0]  op;
        logic        bw;
        logic [1:0]  am;
        logic        ad;
        logic [3:0]  src;
        logic [3:0]  dst;
        logic [9:0]  jofs;
        logic [15:0] e1;
        logic [15:0] e2;
        logic [15:0] raw;
    } req_t;

    logic          mclk;
    logic          puc_rst;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_fmt;
    logic [3:0]    req_op;
    logic          req_bw;
    logic [1:0]    req_as;
    logic          req_ad;
    logic [3:0]    req_src;
    logic [3:0]    req_dst;
    logic [9:0]    req_jofs;
    logic [15:0]   req_ext1;
    logic [15:0]   req_ext2;
    logic [15:0]   req_raw;
    logic          addr_load;
    logic [AW-1:0] addr_val;
    logic          pmem_wen;
    logic [AW-1:0] pmem_addr;
    logic [15:0]   pmem_din;
    logic [15:0]   inst_count;
    logic          enc_err;
    logic          addr_wrap;
    logic [1:0]    dbg_state;

    msp_inst_encoder #(
        .PMEM_AW   (AW),
        .BASE_ADDR ('0)
    ) dut (
        .mclk       (mclk),
        .puc_rst    (puc_rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_fmt    (req_fmt),
        .req_op     (req_op),
        .req_bw     (req_bw),
        .req_as     (req_as),
        .req_ad     (req_ad),
        .req_src    (req_src),
        .req_dst    (req_dst),
        .req_jofs   (req_jofs),
        .req_ext1   (req_ext1),
        .req_ext2   (req_ext2),
        .req_raw    (req_raw),
        .addr_load  (addr_load),
        .addr_val   (addr_val),
        .pmem_wen   (pmem_wen),
        .pmem_addr  (pmem_addr),
        .pmem_din   (pmem_din),
        .inst_count (inst_count),
        .enc_err    (enc_err),
        .addr_wrap  (addr_wrap),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int            checks   = 0;
    int            failures = 0;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  mon_exp;
    int            mptr     = 0;
    int            mcount   = 0;
    logic          mwrap    = 1'b0;
    int            exp_err  = 0;
    int            seen_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    // Returns the number of words the instruction occupies, 0 when illegal.
    function automatic int model_encode(input req_t r, output logic [15:0] w0,
                                        output logic [15:0] w1, output logic [15:0] w2);
        int   op;
        int   opc;
        logic legal;
        logic sx;
        logic dx;
        op = int'(r.op);
        case (r.fmt)
            2'd0: begin
                legal = (op <= 6);
                opc = (op == 6) ? 'h1300
                      : 'h1000 + op * 128 + int'(r.bw) * 64 + int'(r.am) * 16 + int'(r.src);
            end
            2'd1: begin
                legal = (op < 8);
                opc = 'h2000 + op * 1024 + int'(r.jofs);
            end
            2'd2: begin
                legal = (op >= 4);
                opc = op * 4096 + int'(r.src) * 256 + int'(r.ad) * 128 + int'(r.bw) * 64
                      + int'(r.am) * 16 + int'(r.dst);
            end
            default: begin
                legal = 1'b1;
                opc = int'(r.raw);
            end
        endcase
        sx = (((r.fmt == 2'd0) && (op != 6)) || (r.fmt == 2'd2)) &&
             (((r.am == 2'd1) && (r.src != 4'd3)) || ((r.am == 2'd3) && (r.src == 4'd0)));
        dx = (r.fmt == 2'd2) && r.ad;
        w0 = opc[15:0];
        w1 = r.e1;
        w2 = r.e2;
        return legal ? 1 + int'(sx) + int'(dx) : 0;
    endfunction

    task automatic push_expect(input req_t r);
        logic [15:0] w0, w1, w2, d;
        int n;
        n = model_encode(r, w0, w1, w2);
        if (n == 0) begin
            exp_err++;
        end else begin
            for (int i = 0; i < n; i++) begin
                d = (i == 0) ? w0 : (i == 1) ? w1 : w2;
                if (mptr == DEPTH - 1) mwrap = 1'b1;
                exp_q.push_back({mptr[AW-1:0], d});
                mptr = (mptr + 1) % DEPTH;
            end
            mcount++;
        end
    endtask

    function automatic req_t mk(input int fmt, input int op, input int bw, input int am,
                                input int ad, input int src, input int dst, input int jofs,
                                input int e1, input int e2, input int raw);
        req_t r;
        r.fmt  = 2'(fmt);
        r.op   = 4'(op);
        r.bw   = 1'(bw);
        r.am   = 2'(am);
        r.ad   = 1'(ad);
        r.src  = 4'(src);
        r.dst  = 4'(dst);
        r.jofs = 10'(jofs);
        r.e1   = 16'(e1);
        r.e2   = 16'(e2);
        r.raw  = 16'(raw);
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.fmt  = 2'($urandom_range(0, 3));
        r.op   = 4'($urandom_range(0, 15));
        r.bw   = 1'($urandom_range(0, 1));
        r.am   = 2'($urandom_range(0, 3));
        r.ad   = 1'($urandom_range(0, 1));
        r.src  = 4'($urandom_range(0, 15));
        r.dst  = 4'($urandom_range(0, 15));
        r.jofs = 10'($urandom_range(0, 1023));
        r.e1   = 16'($urandom_range(0, 65535));
        r.e2   = 16'($urandom_range(0, 65535));
        r.raw  = 16'($urandom_range(0, 65535));
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_fields(input req_t r);
        req_fmt  = r.fmt;
        req_op   = r.op;
        req_bw   = r.bw;
        req_as   = r.am;
        req_ad   = r.ad;
        req_src  = r.src;
        req_dst  = r.dst;
        req_jofs = r.jofs;
        req_ext1 = r.e1;
        req_ext2 = r.e2;
        req_raw  = r.raw;
    endtask

    // Returns 1 ns after the accepting edge.
    task automatic issue(input req_t r);
        int guard = 0;
        @(negedge mclk);
        while (!req_ready && guard < 20) begin
            @(negedge mclk);
            guard++;
        end
        if (!req_ready) begin
            check("ready_timeout", 32'(req_ready), 32'd1);
        end else begin
            drive_fields(r);
            req_valid = 1'b1;
            push_expect(r);
            @(posedge mclk);
            #1 req_valid = 1'b0;
        end
    endtask

    task automatic load_ptr(input int v);
        int guard = 0;
        @(negedge mclk);
        while (!req_ready && guard < 20) begin
            @(negedge mclk);
            guard++;
        end
        addr_load = 1'b1;
        addr_val  = AW'(v);
        @(posedge mclk);
        #1 addr_load = 1'b0;
        mptr = v % DEPTH;
    endtask

    task automatic wait_idle(input string name);
        int guard = 0;
        @(negedge mclk);
        while (!req_ready && guard < 20) begin
            @(negedge mclk);
            guard++;
        end
        check({name, "_ready"}, 32'(req_ready), 32'd1);
        check({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        check({name, "_inst_count"}, 32'(inst_count), 32'(mcount[15:0]));
        check({name, "_addr_wrap"}, 32'(addr_wrap), 32'(mwrap));
    endtask

    // ---------------- monitor ----------------
    always @(negedge mclk) begin
        if (!puc_rst) begin
            if (enc_err) seen_err++;
            if (pmem_wen) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=0x%0h@0x%0h required=no_write",
                             pmem_din, pmem_addr);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("wr_addr", 32'(pmem_addr), 32'(mon_exp[W-1:16]));
                    check("wr_data", 32'(pmem_din), 32'(mon_exp[15:0]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    req_t dir_req[6];
    logic [15:0] dir_opc[6];

    initial begin
        req_t r;
        puc_rst   = 1'b1;
        req_valid = 1'b0;
        addr_load = 1'b0;
        addr_val  = '0;
        drive_fields(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        repeat (3) @(posedge mclk);
        @(negedge mclk);
        check("rst_wen", 32'(pmem_wen), 32'd0);
        check("rst_din", 32'(pmem_din), 32'd0);
        check("rst_inst_count", 32'(inst_count), 32'd0);
        check("rst_enc_err", 32'(enc_err), 32'd0);
        check("rst_addr_wrap", 32'(addr_wrap), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        puc_rst = 1'b0;

        // Test-plan instructions with their documented opcode words
        dir_req[0] = mk(2, 4, 0, 3, 1, 0, 2, 0, 'h1234, 'h0200, 0); dir_opc[0] = 16'h40B2;
        dir_req[1] = mk(2, 5, 0, 1, 0, 3, 4, 0, 'hAAAA, 'hBBBB, 0); dir_opc[1] = 16'h5314;
        dir_req[2] = mk(0, 4, 1, 0, 0, 5, 0, 0, 'hCCCC, 'hDDDD, 0); dir_opc[2] = 16'h1245;
        dir_req[3] = mk(0, 5, 0, 3, 0, 0, 0, 0, 'hF000, 'h1111, 0); dir_opc[3] = 16'h12B0;
        dir_req[4] = mk(1, 7, 0, 0, 0, 0, 0, 'h3FF, 0, 0, 0);      dir_opc[4] = 16'h3FFF;
        dir_req[5] = mk(0, 6, 0, 3, 0, 0, 0, 0, 'h2222, 'h3333, 0); dir_opc[5] = 16'h1300;

        // MOV #0x1234,&0x0200: three writes in consecutive cycles
        issue(dir_req[0]);
        for (int i = 0; i < 3; i++) begin
            @(negedge mclk);
            check("mov_wen_burst", 32'(pmem_wen), 32'd1);
            if (i == 0) check("mov_opc", 32'(pmem_din), 32'(dir_opc[0]));
        end
        @(negedge mclk);
        check("mov_wen_end", 32'(pmem_wen), 32'd0);
        wait_idle("mov");
        check("mov_inst_count_one", 32'(inst_count), 32'd1);

        for (int i = 1; i < 6; i++) begin
            issue(dir_req[i]);
            @(negedge mclk);
            check("dir_opc", 32'(pmem_din), 32'(dir_opc[i]));
            wait_idle("dir");
        end

        // Illegal two-op op=2 and single-op op=7
        for (int i = 0; i < 2; i++) begin
            r = (i == 0) ? mk(2, 2, 0, 0, 0, 4, 5, 0, 0, 0, 0) : mk(0, 7, 0, 0, 0, 4, 0, 0, 0, 0, 0);
            issue(r);
            @(negedge mclk);
            check("illegal_err_pulse", 32'(enc_err), 32'd1);
            check("illegal_no_write", 32'(pmem_wen), 32'd0);
            @(negedge mclk);
            check("illegal_err_drop", 32'(enc_err), 32'd0);
            wait_idle("illegal");
        end

        // addr_load competing with a request: load wins, then 3 words wrap the pointer
        @(negedge mclk);
        drive_fields(dir_req[0]);
        req_valid = 1'b1;
        addr_load = 1'b1;
        addr_val  = '1;
        #1 check("load_blocks_ready", 32'(req_ready), 32'd0);
        @(posedge mclk);
        #1 addr_load = 1'b0;
        mptr = DEPTH - 1;
        push_expect(dir_req[0]);
        @(posedge mclk);
        #1 req_valid = 1'b0;
        wait_idle("wrap");
        check("wrap_sticky", 32'(addr_wrap), 32'd1);

        // Randomized stream with occasional pointer loads near the top of memory
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                load_ptr(($urandom_range(0, 1) == 1) ? int'($urandom_range(DEPTH - 4, DEPTH - 1))
                                                     : int'($urandom_range(0, DEPTH - 1)));
            end
            repeat ($urandom_range(0, 2)) @(posedge mclk);
            issue(rand_req());
        end
        wait_idle("random");

        // Reset while the first extension word is on the bus
        issue(dir_req[0]);
        @(posedge mclk);
        #2 puc_rst = 1'b1;
        exp_q.delete();
        @(negedge mclk);
        check("midrst_wen", 32'(pmem_wen), 32'd0);
        check("midrst_inst_count", 32'(inst_count), 32'd0);
        check("midrst_addr_wrap", 32'(addr_wrap), 32'd0);
        @(negedge mclk);
        puc_rst = 1'b0;
        mptr   = 0;
        mcount = 0;
        mwrap  = 1'b0;
        #1 check("midrst_ready", 32'(req_ready), 32'd1);
        issue(dir_req[1]);
        @(negedge mclk);
        check("midrst_base_addr", 32'(pmem_addr), 32'd0);
        wait_idle("post_rst");

        check("enc_err_pulses", 32'(seen_err), 32'(exp_err));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
